// File: rtl/fetch_ctrl_if.sv
// Loader handshake and instruction-memory write port shared by the loader,
// fetch_ctrl and the instruction memory.
interface fetch_ctrl_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [XLEN-1:0]       ld_data;
  logic                  ld_done;
  logic                  ld_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [XLEN-1:0]       imem_wdata;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_done,
    input  ld_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_done,
    output ld_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch PC controller: LOAD (program download) / RUN (fetch) / HALT.
// Define FETCH_CTRL_PERF_EN to build the fetched-instruction counter.
module fetch_ctrl #(
  parameter int              XLEN       = 32,
  parameter int              ADDR_WIDTH = 8,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            halt_req,
  input  logic            resume,
  fetch_ctrl_if.slave     ld,
  output logic [XLEN-1:0] PC,
  output logic            fetch_valid,
  output logic            misalign,
  output logic [1:0]      state_o,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_set;
  logic            in_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_q | mis_set;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mis_set     = 1'b0;
    fetch_valid = 1'b0;
    case (state_q)
      S_LOAD: begin
        pc_d = RESET_PC;
        if (ld.ld_done) state_d = S_RUN;
      end
      S_RUN: begin
        fetch_valid = 1'b1;
        // A redirect always lands, even in the cycle that halts; a halt
        // without redirect freezes PC regardless of StallF.
        if (PCSrcE) begin
          pc_d    = {PCTargetE[XLEN-1:2], 2'b00};
          mis_set = |PCTargetE[1:0];
        end else if (!(StallF || halt_req)) begin
          pc_d = PCPlus4F;
        end
        if (halt_req) state_d = S_HALT;
      end
      S_HALT: begin
        if (resume && !halt_req) state_d = S_RUN;
      end
      default: begin
        state_d = S_LOAD;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // Gated by rst_n so a write in flight is dropped the instant reset falls.
  assign in_load       = (state_q == S_LOAD) && rst_n;
  assign ld.ld_ready   = in_load;
  assign ld.imem_we    = in_load && ld.ld_valid;
  assign ld.imem_waddr = in_load ? ld.ld_addr : '0;
  assign ld.imem_wdata = in_load ? ld.ld_data : '0;

  assign PC       = pc_q;
  assign misalign = mis_q;
  assign state_o  = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       cnt_q <= '0;
    else if (state_q == S_RUN && !StallF && !PCSrcE) cnt_q <= cnt_q + 32'd1;
  end
  assign fetch_count = cnt_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: vector table for RUN/HALT behaviour plus
// hand sequences for load, async reset and the perf counter.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, PCSrcE, halt_req, resume;
  logic [31:0] PCTargetE, PCPlus4F, PC, fetch_count;
  logic        fetch_valid, misalign;
  logic [1:0]  state_o;
  int          checks = 0;
  int          errors = 0;

  fetch_ctrl_if #(.XLEN(32), .ADDR_WIDTH(8)) ldif ();

  fetch_ctrl #(.XLEN(32), .ADDR_WIDTH(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .PCPlus4F(PCPlus4F), .halt_req(halt_req),
    .resume(resume), .ld(ldif.slave), .PC(PC), .fetch_valid(fetch_valid),
    .misalign(misalign), .state_o(state_o), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  // fetch stage model: sequential PC is current PC + 4
  assign PCPlus4F = PC + 32'd4;

  typedef struct {
    logic        stall, src;
    logic [31:0] tgt;
    logic        halt, res, ldv, ldd;
    logic [31:0] epc;
    logic [1:0]  est;
    logic        efv, emis;
  } vec_t;

  vec_t        tbl [17];
  logic [31:0] prog [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    StallF = 0; PCSrcE = 0; PCTargetE = '0; halt_req = 0; resume = 0;
    ldif.ld_valid = 0; ldif.ld_addr = '0; ldif.ld_data = '0; ldif.ld_done = 0;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    prog[0] = 32'h00500093; prog[1] = 32'h00a00113;
    prog[2] = 32'h002081b3; prog[3] = 32'h00000073;
    //            stall src tgt           halt res ldv ldd epc           est  fv mis
    tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h4,        2'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h8,        2'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hC,        2'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hC,        2'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h10,       2'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h10,       2'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h80,       1'b0, 1'b0, 1'b1, 1'b1, 32'h10,       2'd2, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h10,       2'd2, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h10,       2'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h14,       2'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'h42,       1'b0, 1'b0, 1'b0, 1'b0, 32'h40,       2'd1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h44,       2'd1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 32'h80,       1'b1, 1'b0, 1'b0, 1'b0, 32'h80,       2'd2, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h80,       2'd1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 2'd1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'd1, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h4,        2'd1, 1'b1, 1'b1};

    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_state",    32'(state_o), 32'd0);
    chk("rst_pc",       PC, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_fv",       32'(fetch_valid), 32'd0);
    chk("rst_count",    fetch_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("load_ready", 32'(ldif.ld_ready), 32'd1);

    // program download, combinational pass-through to the write port
    for (int i = 0; i < 4; i++) begin
      ldif.ld_valid = 1'b1; ldif.ld_addr = 8'(i); ldif.ld_data = prog[i];
      ldif.ld_done  = (i == 3);
      #1;
      chk("load_we",    32'(ldif.imem_we), 32'd1);
      chk("load_waddr", 32'(ldif.imem_waddr), 32'(i));
      chk("load_wdata", ldif.imem_wdata, prog[i]);
      if (i < 3) chk("load_state", 32'(state_o), 32'd0);
      step();
    end
    idle();
    #1;
    chk("run_state", 32'(state_o), 32'd1);
    chk("run_pc0",   PC, 32'h0);
    chk("run_fv",    32'(fetch_valid), 32'd1);
    chk("run_we",    32'(ldif.imem_we), 32'd0);

    foreach (tbl[k]) begin
      StallF = tbl[k].stall; PCSrcE = tbl[k].src; PCTargetE = tbl[k].tgt;
      halt_req = tbl[k].halt; resume = tbl[k].res;
      ldif.ld_valid = tbl[k].ldv; ldif.ld_done = tbl[k].ldd;
      ldif.ld_addr = 8'h33; ldif.ld_data = 32'hDEADBEEF;
      step();
      chk($sformatf("v%0d_pc", k),    PC, tbl[k].epc);
      chk($sformatf("v%0d_state", k), 32'(state_o), 32'(tbl[k].est));
      chk($sformatf("v%0d_fv", k),    32'(fetch_valid), 32'(tbl[k].efv));
      chk($sformatf("v%0d_mis", k),   32'(misalign), 32'(tbl[k].emis));
      chk($sformatf("v%0d_we", k),    32'(ldif.imem_we), 32'd0);
      chk($sformatf("v%0d_wdata", k), ldif.imem_wdata, 32'h0);
      chk($sformatf("v%0d_ready", k), 32'(ldif.ld_ready), 32'd0);
    end

    // asynchronous reset in RUN with sticky misalign set
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_pc",    PC, 32'h0);
    chk("arst_mis",   32'(misalign), 32'd0);
    chk("arst_fv",    32'(fetch_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // perf counter: 5 unstalled fetches then a redirect
    ldif.ld_done = 1'b1;
    step();
    idle();
    for (int i = 0; i < 5; i++) step();
`ifdef FETCH_CTRL_PERF_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    chk("perf_pc",   PC, 32'h14);
    chk("perf_cnt5", fetch_count, exp_cnt);
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    step();
    idle();
    chk("perf_redir_pc",  PC, 32'h100);
    chk("perf_redir_cnt", fetch_count, exp_cnt);

    // reset mid-load with a live write
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ldif.ld_valid = 1'b1; ldif.ld_addr = 8'h05; ldif.ld_data = 32'h12345678;
    #1;
    chk("mid_we_pre", 32'(ldif.imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_we",    32'(ldif.imem_we), 32'd0);
    chk("mid_state", 32'(state_o), 32'd0);
    chk("mid_pc",    PC, 32'h0);
    chk("mid_cnt",   fetch_count, 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
